// File: rtl/multi_bit_f2s_pacer.sv
// multi_bit_f2s_pacer
// Fast-domain pacing FIFO that sits in front of the multi-bit fast-to-slow
// synchronizer. Bursty ready/valid words are buffered, then re-issued as
// single-cycle valid_out pulses at least GAP clka cycles apart. dout holds
// its value between pulses, so the slow side can sample it safely.
module multi_bit_f2s_pacer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int GAP        = 8
) (
    input  logic                       clka,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       valid_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = $clog2(GAP) + 1;

    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

    // Storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  ovf_q;

    // Issue stage registers
    logic [DATA_WIDTH-1:0] dout_p1;
    logic                  vld_p1;

    // Per-edge decisions, all taken from registered state only
    logic push;
    logic drop;
    logic issue;

    // Occupancy after one edge: +1 for an accepted word, -1 for an issued one.
    function automatic logic [LVL_W-1:0] next_level(
        input logic [LVL_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        logic [LVL_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + LVL_W'(1);
        end else if (dec && !inc) begin
            nxt = cur - LVL_W'(1);
        end
        return nxt;
    endfunction

    // Holdoff after one edge: reload on issue, otherwise count down to zero.
    function automatic logic [GAP_W-1:0] next_gap(
        input logic [GAP_W-1:0] cur,
        input logic             reload
    );
        logic [GAP_W-1:0] nxt;
        nxt = cur;
        if (reload) begin
            nxt = GAP_RELOAD;
        end else if (cur != '0) begin
            nxt = cur - GAP_W'(1);
        end
        return nxt;
    endfunction

    // ready_out depends on the stored level only, never on valid_in, so a word
    // offered while full is refused even if an issue frees a slot that edge.
    assign ready_out = (level_q < LVL_FULL);
    assign push      = valid_in && ready_out;
    assign drop      = valid_in && !ready_out;
    assign issue     = (level_q != '0) && (gap_cnt == '0);

    assign level     = level_q;
    assign overflow  = ovf_q;
    assign dout      = dout_p1;
    assign valid_out = vld_p1;

    // Write port: payload storage is not reset; pointers make stale entries unreachable.
    always_ff @(posedge clka) begin
        if (push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, holdoff counter and sticky overflow.
    always_ff @(posedge clka) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            gap_cnt <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q <= next_level(level_q, push, issue);
            gap_cnt <= next_gap(gap_cnt, issue);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // ---- issue stage: head word to dout with a one-cycle valid pulse ----
    always_ff @(posedge clka) begin
        if (rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                dout_p1 <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_multi_bit_f2s_pacer.sv
// Testbench for multi_bit_f2s_pacer: directed scenarios followed by random
// traffic with occasional resets. A queue-based reference model predicts
// every pulse into a scoreboard; a negedge monitor checks the DUT against it.
module tb_multi_bit_f2s_pacer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 8;

    logic          clka = 1'b0;
    logic          rst  = 1'b1;
    logic [DW-1:0] din  = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [DW-1:0] dout;
    logic          valid_out;
    logic [$clog2(DEPTH):0] level;
    logic          overflow;

    multi_bit_f2s_pacer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clka      (clka),
        .rst       (rst),
        .din       (din),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .dout      (dout),
        .valid_out (valid_out),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [DW-1:0] data;
        int            edge_n;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] q[$];
    int            n       = 0;
    int            next_ok = 0;
    bit            m_init  = 0;
    bit            m_ovf   = 0;
    logic [DW-1:0] m_dout  = '0;
    int            m_level = 0;
    bit            acc;
    bit            iss;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, n);
        end
    endtask

    // Reference model: a word queue plus the earliest edge at which the next
    // issue is allowed. Evaluated on pre-edge state at every rising edge.
    always @(posedge clka) begin
        n++;
        if (rst) begin
            q.delete();
            m_ovf   = 0;
            m_dout  = '0;
            next_ok = 0;
            m_init  = 1;
        end else begin
            acc = valid_in && (q.size() < DEPTH);
            iss = (q.size() > 0) && (n >= next_ok);
            if (valid_in && !acc) m_ovf = 1;
            if (iss) begin
                m_dout = q.pop_front();
                sb.push_back('{m_dout, n});
                next_ok = n + GAP;
            end
            if (acc) q.push_back(din);
        end
        m_level = q.size();
    end

    // Monitor: compare registered outputs half a cycle after each edge.
    always @(negedge clka) begin
        exp_t e;
        if (m_init) begin
            check("level", 32'(level), 32'(m_level));
            check("ready_out", 32'(ready_out), 32'(m_level < DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("dout_hold", 32'(dout), 32'(m_dout));
            if (valid_out === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_pulse", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_data", 32'(dout), 32'(e.data));
                    check("pulse_edge", 32'(n), 32'(e.edge_n));
                end
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                check("missing_pulse", 32'(valid_out), 32'd1);
            end else begin
                check("valid_out_low", 32'(valid_out), 32'd0);
            end
        end
    end

    task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d);
        @(negedge clka);
        #1;
        rst      = r;
        valid_in = v;
        din      = d;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, '0);
    endtask

    initial begin
        // Reset held three cycles with valid_in asserted
        rst = 1; valid_in = 1; din = 8'h77;
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'h77);
        idle(3);

        // Single word
        cyc(0, 1, 8'hA5);
        idle(12);

        // Burst of four
        for (int i = 1; i <= 4; i++) cyc(0, 1, 8'(i));
        idle(40);

        // Overflow: six back-to-back words
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'h10 + i));
        idle(50);

        // Full FIFO while an issue happens: clear flag, then hold valid_in
        cyc(1, 0, '0);
        idle(2);
        for (int i = 0; i < 12; i++) cyc(0, 1, 8'(8'h40 + i));
        idle(45);

        // Reset mid-burst with words queued and holdoff running
        cyc(1, 0, '0);
        idle(2);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'h60 + i));
        idle(2);
        cyc(1, 0, '0);
        cyc(0, 1, 8'h99);
        idle(15);

        // Random traffic with varying load and sparse resets
        for (int p = 0; p < 30; p++) begin
            int dens;
            dens = $urandom_range(5, 100);
            for (int i = 0; i < 100; i++) begin
                bit r;
                r = ($urandom_range(0, 299) == 0);
                cyc(r, ($urandom_range(1, 100) <= dens), 8'($urandom));
            end
        end
        idle(GAP * (DEPTH + 2));

        @(negedge clka);
        #2;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
